// File: rtl/imm_extend_pipe.sv
// Registered immediate extender with a valid/ready handshake and a two-entry skid buffer.
// Decode feeds one raw immediate per cycle; execute may stall without losing items.
module imm_extend_pipe #(
    parameter int IMM_WIDTH = 8,
    parameter int WORD_SIZE = 16,
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IMM_WIDTH-1:0] in_imm,
    input  logic [1:0]           in_mode,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_word,
    output logic [TAG_WIDTH-1:0] out_tag
);

    localparam int PAD = WORD_SIZE - IMM_WIDTH;

    localparam logic [1:0] MODE_SIGN      = 2'd0;
    localparam logic [1:0] MODE_ZERO      = 2'd1;
    localparam logic [1:0] MODE_UPPER     = 2'd2;
    localparam logic [1:0] MODE_SIGN_SHL1 = 2'd3;

    logic                 r_main_valid;
    logic [WORD_SIZE-1:0] r_main_word;
    logic [TAG_WIDTH-1:0] r_main_tag;
    logic                 r_skid_valid;
    logic [WORD_SIZE-1:0] r_skid_word;
    logic [TAG_WIDTH-1:0] r_skid_tag;

    logic [WORD_SIZE-1:0] w_sign;
    logic [WORD_SIZE-1:0] w_ext;
    logic                 w_accept;
    logic                 w_retire;

    assign w_sign = {{PAD{in_imm[IMM_WIDTH-1]}}, in_imm};

    always_comb begin
        w_ext = w_sign;
        case (in_mode)
            MODE_SIGN:      w_ext = w_sign;
            MODE_ZERO:      w_ext = {{PAD{1'b0}}, in_imm};
            MODE_UPPER:     w_ext = {in_imm, {PAD{1'b0}}};
            MODE_SIGN_SHL1: w_ext = {w_sign[WORD_SIZE-2:0], 1'b0};
            default:        w_ext = w_sign;
        endcase
    end

    // in_ready depends only on registered state, so out_ready never reaches it combinationally
    assign w_accept = in_valid && !r_skid_valid;
    assign w_retire = r_main_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_main_valid <= 1'b0;
            r_main_word  <= '0;
            r_main_tag   <= '0;
            r_skid_valid <= 1'b0;
        end else if (w_retire) begin
            if (r_skid_valid) begin
                r_main_word  <= r_skid_word;
                r_main_tag   <= r_skid_tag;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_main_word  <= w_ext;
                r_main_tag   <= in_tag;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_accept) begin
            if (!r_main_valid) begin
                r_main_valid <= 1'b1;
                r_main_word  <= w_ext;
                r_main_tag   <= in_tag;
            end else begin
                r_skid_valid <= 1'b1;
            end
        end
    end

    // Skid payload is qualified by r_skid_valid and needs no reset
    always_ff @(posedge clk) begin
        if (!reset && !w_retire && w_accept && r_main_valid) begin
            r_skid_word <= w_ext;
            r_skid_tag  <= in_tag;
        end
    end

    assign in_ready  = !r_skid_valid;
    assign out_valid = r_main_valid;
    assign out_word  = r_main_word;
    assign out_tag   = r_main_tag;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: a 2-deep queue model predicts handshake and
// data; extension results come from plain signed arithmetic.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_imm;
    logic [1:0]  in_mode;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_word;
    logic [3:0]  out_tag;

    logic        b_reset;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [4:0]  b_in_imm;
    logic [1:0]  b_in_mode;
    logic [3:0]  b_in_tag;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [31:0] b_out_word;
    logic [3:0]  b_out_tag;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] word;
        logic [3:0]  tag;
    } item_t;

    item_t mq[$];

    always #5 clk = ~clk;

    imm_extend_pipe #(.IMM_WIDTH(8), .WORD_SIZE(16), .TAG_WIDTH(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_imm(in_imm), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_tag(out_tag)
    );

    imm_extend_pipe #(.IMM_WIDTH(5), .WORD_SIZE(32), .TAG_WIDTH(4)) dut_b (
        .clk(clk), .reset(b_reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_imm(b_in_imm), .in_mode(b_in_mode), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_word(b_out_word), .out_tag(b_out_tag)
    );

    function automatic logic [31:0] ref_ext(int iw, int ws, logic [31:0] imm, logic [1:0] mode);
        longint v;
        longint m;
        v = longint'(imm) & ((64'sd1 <<< iw) - 64'sd1);
        if ((mode == 2'd0 || mode == 2'd3) && v >= (64'sd1 <<< (iw - 1)))
            v = v - (64'sd1 <<< iw);
        if (mode == 2'd2) v = v * (64'sd1 <<< (ws - iw));
        if (mode == 2'd3) v = v * 2;
        m = (64'sd1 <<< ws) - 64'sd1;
        return 32'(v & m);
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // One clock: model decides accept/retire from its own occupancy, then outputs are checked.
    task automatic cyc(output bit acc, output bit ret, output logic [3:0] ret_tag);
        bit was_reset;
        was_reset = reset;
        acc = in_valid && (mq.size() < 2) && !reset;
        ret = (mq.size() > 0) && out_ready && !reset;
        ret_tag = (mq.size() > 0) ? mq[0].tag : 4'h0;
        @(posedge clk);
        #1;
        if (was_reset) begin
            mq.delete();
        end else begin
            if (ret) void'(mq.pop_front());
            if (acc) mq.push_back('{ref_ext(8, 16, 32'(in_imm), in_mode), in_tag});
        end
        chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
        chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("out_word", 32'(out_word), mq[0].word);
            chk("out_tag", 32'(out_tag), 32'(mq[0].tag));
        end
        if (was_reset) begin
            chk("reset_word", 32'(out_word), 32'h0);
            chk("reset_tag", 32'(out_tag), 32'h0);
        end
    endtask

    task automatic sweep(input logic [7:0] imm, input logic [1:0] mode, input logic [3:0] tag,
                         input logic [15:0] exp);
        bit a, r;
        logic [3:0] t;
        in_valid = 1'b1; in_imm = imm; in_mode = mode; in_tag = tag; out_ready = 1'b1;
        cyc(a, r, t);
        chk("sweep_acc", 32'(a), 32'h1);
        chk("sweep_word", 32'(out_word), 32'(exp));
        chk("sweep_tag", 32'(out_tag), 32'(tag));
    endtask

    initial begin
        bit a, r;
        logic [3:0] t;
        logic [15:0] held;
        int nt, cycles, sent, got;
        logic [3:0] tags[$];

        reset = 1'b1; in_valid = 1'b0; in_imm = '0; in_mode = '0; in_tag = '0; out_ready = 1'b0;
        b_reset = 1'b1; b_in_valid = 1'b0; b_in_imm = '0; b_in_mode = '0; b_in_tag = '0;
        b_out_ready = 1'b0;
        cyc(a, r, t);
        cyc(a, r, t);
        reset = 1'b0;
        b_reset = 1'b0;
        cyc(a, r, t);

        // mode sweep
        sweep(8'h80, 2'd0, 4'h1, 16'hFF80);
        sweep(8'h80, 2'd1, 4'h2, 16'h0080);
        sweep(8'h12, 2'd2, 4'h3, 16'h1200);
        sweep(8'hFF, 2'd3, 4'h4, 16'hFFFE);
        sweep(8'h7F, 2'd0, 4'h5, 16'h007F);
        in_valid = 1'b0;
        cyc(a, r, t);
        cyc(a, r, t);

        // backpressure: three stalled cycles, then drain tags 1..6
        out_ready = 1'b0;
        nt = 1;
        in_valid = 1'b1; in_mode = 2'd1; in_tag = 4'(nt); in_imm = 8'(nt);
        held = '0;
        for (int i = 0; i < 3; i++) begin
            cyc(a, r, t);
            if (a) begin nt++; in_tag = 4'(nt); in_imm = 8'(nt); end
            if (i == 1) held = out_word;
        end
        chk("bp_accepted", 32'(nt - 1), 32'd2);
        chk("bp_full_ready", 32'(in_ready), 32'h0);
        chk("bp_stable", 32'(out_word), 32'(held));
        out_ready = 1'b1;
        cycles = 0;
        while (tags.size() < 6 && cycles < 50) begin
            cyc(a, r, t);
            if (r) tags.push_back(t);
            if (a) begin
                nt++;
                if (nt > 6) in_valid = 1'b0;
                else begin in_tag = 4'(nt); in_imm = 8'(nt); end
            end
            cycles++;
        end
        chk("bp_count", 32'(tags.size()), 32'd6);
        for (int i = 0; i < tags.size(); i++) chk("bp_order", 32'(tags[i]), 32'(i + 1));
        in_valid = 1'b0;
        cyc(a, r, t);

        // random valid/ready
        sent = 0; got = 0; cycles = 0;
        while ((sent < 1000 || mq.size() > 0) && cycles < 20000) begin
            if (!in_valid && sent < 1000 && $urandom_range(0, 99) < 70) begin
                in_valid = 1'b1;
                in_imm = 8'($urandom);
                in_mode = 2'($urandom);
                in_tag = 4'($urandom);
            end
            out_ready = ($urandom_range(0, 99) < 50);
            cyc(a, r, t);
            if (r) got++;
            if (a) begin sent++; in_valid = 1'b0; end
            cycles++;
        end
        chk("rand_timeout", 32'(cycles < 20000), 32'h1);
        chk("rand_retired", 32'(got), 32'd1000);

        // reset mid-stream with both entries full
        out_ready = 1'b0;
        in_valid = 1'b1; in_mode = 2'd0; in_imm = 8'h33; in_tag = 4'h7;
        cyc(a, r, t);
        in_tag = 4'h8;
        cyc(a, r, t);
        chk("rst_full", 32'(in_ready), 32'h0);
        reset = 1'b1; in_tag = 4'hA; in_imm = 8'hAA;
        cyc(a, r, t);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_ready", 32'(in_ready), 32'h1);
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cyc(a, r, t);
        chk("rst_no_ghost", 32'(out_valid), 32'h0);

        // parameter corner: IMM_WIDTH=5, WORD_SIZE=32
        b_out_ready = 1'b1; b_in_valid = 1'b1; b_in_imm = 5'h10; b_in_tag = 4'h3;
        b_in_mode = 2'd0;
        @(posedge clk); #1;
        chk("b_valid", 32'(b_out_valid), 32'h1);
        chk("b_sign", b_out_word, 32'hFFFFFFF0);
        chk("b_tag", 32'(b_out_tag), 32'h3);
        b_in_mode = 2'd2; b_in_tag = 4'h4;
        @(posedge clk); #1;
        chk("b_upper", b_out_word, 32'h80000000);
        b_in_mode = 2'd3; b_in_tag = 4'h5;
        @(posedge clk); #1;
        chk("b_shl1", b_out_word, 32'hFFFFFFE0);
        chk("b_tag2", 32'(b_out_tag), 32'h5);
        b_in_valid = 1'b0;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
